// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max-pooling engine over a raster-order pixel stream.
// Even rows fold horizontal pairs into a half-row line buffer; odd rows
// combine their horizontal pair maxima with the buffered value and emit one pooled pixel.
module maxpool_2x2_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_WIDTH  = 100,
    parameter int unsigned NUM_ROWS   = 100,
    parameter int unsigned IDX_WIDTH  = 12
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Clr,
    input  logic                         En,
    input  logic signed [DATA_WIDTH-1:0] Data_In,
    output logic signed [DATA_WIDTH-1:0] Data_Out,
    output logic                         Out_Valid,
    output logic [IDX_WIDTH-1:0]         Out_Index,
    output logic                         Frame_Done,
    output logic                         Row_Parity
);

    localparam int unsigned LB_DEPTH = ROW_WIDTH / 2;
    localparam int unsigned COL_W    = (ROW_WIDTH > 2) ? $clog2(ROW_WIDTH) : 2;
    localparam int unsigned ROW_W    = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic signed [DATA_WIDTH-1:0] h_q, h_d;
    logic [IDX_WIDTH-1:0]         cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic                         valid_q, valid_d;
    logic                         done_q, done_d;

    logic signed [DATA_WIDTH-1:0] line_buf_q [LB_DEPTH];

    logic                         accept;
    logic                         col_last;
    logic                         row_last;
    logic                         emit;
    logic                         lb_we;
    logic [LB_AW-1:0]             lb_idx;
    logic signed [DATA_WIDTH-1:0] h_max;
    logic signed [DATA_WIDTH-1:0] lb_rd;
    logic signed [DATA_WIDTH-1:0] pool;

    assign accept   = En & ~Clr;
    assign col_last = (col_q == COL_W'(ROW_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(NUM_ROWS - 1));
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = line_buf_q[lb_idx];
    // Odd column closes a horizontal pair; odd row closes the 2x2 window.
    assign emit     = accept & col_q[0] & row_q[0];
    assign lb_we    = accept & col_q[0] & ~row_q[0];

    // Signed maxima: horizontal pair first, then against the buffered upper pair.
    always_comb begin
        h_max = (Data_In > h_q) ? Data_In : h_q;
        pool  = (lb_rd > h_max) ? lb_rd : h_max;
    end

    // Next-state: position counters, pair register, output registers.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (Clr) begin
            col_d = '0;
            row_d = '0;
            h_d   = '0;
            cnt_d = '0;
        end else if (En) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                h_d = Data_In;
            end
            if (emit) begin
                dout_d  = pool;
                idx_d   = cnt_q;
                valid_d = 1'b1;
                done_d  = row_last & col_last;
                cnt_d   = (row_last & col_last) ? '0 : cnt_q + IDX_WIDTH'(1);
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line buffer: no reset, each entry is written on an even row before the odd row reads it.
    always_ff @(posedge Clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= h_max;
        end
    end

    assign Data_Out   = dout_q;
    assign Out_Valid  = valid_q;
    assign Out_Index  = idx_q;
    assign Frame_Done = done_q;
    assign Row_Parity = row_q[0];

endmodule

// File: doc/maxpool_2x2_stream.md
Name: maxpool_2x2_stream

Overview:
- Layer-5 2x2, stride-2 max-pooling engine. Consumes the raster-order feature-map pixel stream, one pixel per enabled cycle, ROW_WIDTH pixels per row.
- Tracks its own row/column position and row parity.
- Keeps a half-row line buffer of horizontal pair maxima from each even row. Combines them with the following odd row to emit one pooled pixel per 2x2 window.
- Sits between the Layer-5 convolution output stream and the pooled-feature writer.

Parameters:
- DATA_WIDTH, 16, pixel width, signed two's complement.
- ROW_WIDTH, 100, pixels per input row; must be even.
- NUM_ROWS, 100, rows per input frame; must be even.
- IDX_WIDTH, 12, width of Out_Index; must hold (ROW_WIDTH/2)*(NUM_ROWS/2)-1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Clr  in  1  synchronous frame restart; priority over En.
- En  in  1  Data_In valid this cycle; pixel accepted on rising edge when En=1 and Clr=0.
- Data_In  in  DATA_WIDTH  input pixel, signed.
- Data_Out  out  DATA_WIDTH  pooled pixel, signed; valid when Out_Valid=1.
- Out_Valid  out  1  single-cycle pulse per pooled pixel.
- Out_Index  out  IDX_WIDTH  linear index of the pooled pixel in the output map, 0-based, raster order.
- Frame_Done  out  1  pulses together with Out_Valid for the last pooled pixel of a frame.
- Row_Parity  out  1  parity of the current input row: 0 = even row (buffering), 1 = odd row (emitting).

Behaviour:
- Reset (Rst=0, async): column counter, row counter, H_Reg, output index counter, Data_Out, Out_Index = 0; Out_Valid, Frame_Done, Row_Parity = 0. Line buffer (ROW_WIDTH/2 x DATA_WIDTH) is not reset; every entry is written before it is read.
- Position counters: Col 0..ROW_WIDTH-1 and Row 0..NUM_ROWS-1 advance only on accepted pixels.
  - Col wraps to 0 after ROW_WIDTH-1 and Row increments.
  - Row wraps to 0 after NUM_ROWS-1, ready for the next frame with no idle cycle.
  - Row_Parity = Row[0], registered.
- Even Col: H_Reg <= Data_In.
- Odd Col:
  - H_max = signed max(H_Reg, Data_In).
  - Even Row: Line_Buf[Col>>1] <= H_max; no output.
  - Odd Row: Data_Out <= signed max(H_max, Line_Buf[Col>>1]); Out_Valid <= 1; Out_Index <= output counter, after which the counter increments.
- Latency: Out_Valid is asserted 1 cycle after the rising edge that accepts the bottom-right pixel of a window.
- Out_Valid and Frame_Done are high for exactly 1 cycle. They deassert on the next edge whether or not En is high.
- Data_Out and Out_Index hold their last value between pulses.
- Frame_Done = 1 when Row=NUM_ROWS-1 and Col=ROW_WIDTH-1 at acceptance. The output counter wraps to 0 at the same time.
- Comparisons are fully signed. On a tie the value is unchanged, so either operand is correct.
- En=0: all state holds; gaps of any length are allowed between any two pixels, including mid-window and mid-row.
- Clr=1: counters, H_Reg and the output counter go to 0; Out_Valid and Frame_Done go to 0; the pixel on Data_In is discarded even if En=1. Line buffer contents are left unchanged.
- Rst asserted mid-frame: immediate return to reset state; the next accepted pixel is treated as Row 0, Col 0.
- No backpressure: the downstream must accept Out_Valid unconditionally. At most one output per 2 input cycles, so back-to-back Out_Valid never occurs.
- Worst-case combinational path is two chained signed comparators plus line-buffer read. The line buffer is a register array or LUT RAM with asynchronous read.

Test Plan:
- Default params; feed ramp pixel(r,c)=(100r+c) mod 32768 continuously for 10000 cycles.
  -> 2500 Out_Valid pulses.
  -> First pulse: Data_Out=101, Out_Index=0, one cycle after pixel (1,1) is accepted.
  -> Last pulse: Data_Out=9999, Out_Index=2499, Frame_Done=1.
  -> Exactly 1 Frame_Done.
- ROW_WIDTH=4, NUM_ROWS=2; rows {-5,-3,8,2} and {-7,-1,0,9}.
  -> Data_Out=-1 at index 0, then 9 at index 1; Frame_Done with the second output.
- Same stream as the first ROW_WIDTH=4, NUM_ROWS=2 case, with random En gaps of 0-5 cycles.
  -> Identical Data_Out/Out_Index sequence; every Out_Valid is a 1-cycle pulse; Row_Parity toggles only after the 4th accepted pixel of a row.
- Default params; pull Rst low at Row=51, Col=37, release, then feed a full ramp frame.
  -> All outputs 0 during reset.
  -> Subsequent frame output is identical to the first scenario, including first Data_Out=101 at Out_Index 0.
- Default params; Clr=1 with En=1 at Row=10, Col=20 (pixel 1020 discarded), then a full ramp frame.
  -> No Out_Valid in the Clr cycle; the next frame starts at Row 0 and matches the first scenario.
- Two back-to-back frames with no gap.
  -> Frame 2's first output has Data_Out=101, Out_Index=0 on the 2501st pulse; 2 Frame_Done pulses total.
